// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 write-only bus driver:
// FSM state encoding, LCD command codes, the power-on init ROMs for the
// 8-bit and 4-bit bus widths, and small elaboration-time helpers.
package hd44780_pkg;

  typedef enum logic [2:0] {
    ST_POR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_EXEC
  } state_e;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_FUNC_8B = 8'h38;
  localparam logic [7:0] CMD_FUNC_4B = 8'h28;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_WAKE    = 8'h30;
  // Function-set nibble 0x2 placed in the high half, used to switch to 4-bit mode
  localparam logic [7:0] CMD_WAKE_4B = 8'h20;

  localparam int INIT_LEN_8B = 7;
  localparam int INIT_LEN_4B = 8;

  // One init step in 4-bit mode: single=1 sends only the high nibble
  typedef struct packed {
    logic       single;
    logic [7:0] code;
  } init_entry_t;

  function automatic logic [7:0] init_rom_8b(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: return CMD_WAKE;
      4'd3:             return CMD_FUNC_8B;
      4'd4:             return CMD_DISP_ON;
      4'd5:             return CMD_CLEAR;
      4'd6:             return CMD_ENTRY;
      default:          return 8'h00;
    endcase
  endfunction

  function automatic init_entry_t init_rom_4b(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: return '{1'b1, CMD_WAKE};
      4'd3:             return '{1'b1, CMD_WAKE_4B};
      4'd4:             return '{1'b0, CMD_FUNC_4B};
      4'd5:             return '{1'b0, CMD_DISP_ON};
      4'd6:             return '{1'b0, CMD_CLEAR};
      4'd7:             return '{1'b0, CMD_ENTRY};
      default:          return '{1'b0, 8'h00};
    endcase
  endfunction

  // Zero-length timings collapse to a single cycle
  function automatic int clamp1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) instructions need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
    return !rs && ((code == CMD_CLEAR) || (code[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/hd44780_delay_counter.sv
// Load/count/done down-counter shared by every timed state of the driver.
// A state lasting N cycles loads N-1 on entry and leaves when done is seen.
module hd44780_delay_counter #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load takes priority; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Reset arms the counter with its start value so the first timed state begins at once
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hd44780_bus_driver.sv
// HD44780 write-only bus driver. Runs the LCD power-on init by itself, then
// accepts one byte + RS flag per valid/ready handshake and strobes it onto the
// LCD pins with setup / enable-high / hold timing and an execution wait.
// Build option: define HD44780_NIBBLE_MODE_EN for a 4-bit bus (DB[7:4] only,
// high nibble then low nibble); left undefined the bus is 8 bits wide.
module hd44780_bus_driver
  import hd44780_pkg::*;
#(
  parameter int T_POR_CYC   = 4_000_000,
  parameter int T_SETUP_CYC = 10,
  parameter int T_EHIGH_CYC = 50,
  parameter int T_HOLD_CYC  = 10,
  parameter int T_EXEC_CYC  = 4_000,
  parameter int T_CLEAR_CYC = 160_000,
  parameter int T_INIT1_CYC = 410_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_db
);

  localparam int POR_C   = clamp1(T_POR_CYC);
  localparam int SETUP_C = clamp1(T_SETUP_CYC);
  localparam int EHIGH_C = clamp1(T_EHIGH_CYC);
  localparam int HOLD_C  = clamp1(T_HOLD_CYC);
  localparam int EXEC_C  = clamp1(T_EXEC_CYC);
  localparam int CLEAR_C = clamp1(T_CLEAR_CYC);
  localparam int INIT1_C = clamp1(T_INIT1_CYC);
  localparam int MAX_C   = max2(max2(max2(POR_C, SETUP_C), max2(EHIGH_C, HOLD_C)),
                                max2(max2(EXEC_C, CLEAR_C), INIT1_C));
  localparam int CNT_W   = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CNT_W-1:0] LD_POR   = CNT_W'(POR_C - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_C - 1);
  localparam logic [CNT_W-1:0] LD_EHIGH = CNT_W'(EHIGH_C - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_C - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_C - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_C - 1);
  localparam logic [CNT_W-1:0] LD_INIT1 = CNT_W'(INIT1_C - 1);

  state_e           state_q;
  logic [3:0]       idx_q;
  logic             hold_rs_q;
  logic [7:0]       hold_code_q;
  logic             ready_q;
  logic             init_done_q;
  logic             lcd_rs_q;
  logic             lcd_e_q;
  logic [7:0]       lcd_db_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;
  logic [7:0]       rom_code;

`ifdef HD44780_NIBBLE_MODE_EN
  localparam int INIT_LEN = INIT_LEN_4B;
  init_entry_t rom_ent;
  logic        rom_single;
  logic        single_q;
  logic        low_q;
  assign rom_ent    = init_rom_4b(idx_q);
  assign rom_code   = rom_ent.code;
  assign rom_single = rom_ent.single;
`else
  localparam int INIT_LEN = INIT_LEN_8B;
  assign rom_code = init_rom_8b(idx_q);
`endif

  // First bus value of a transfer: the whole byte, or its high nibble on a 4-bit bus
  function automatic logic [7:0] bus_first(input logic [7:0] code);
`ifdef HD44780_NIBBLE_MODE_EN
    return {code[7:4], 4'h0};
`else
    return code;
`endif
  endfunction

  // Execution wait: first wake-up write, clear/home, or an ordinary command
  function automatic logic [CNT_W-1:0] exec_load(input logic first_init, input logic rs,
                                                 input logic [7:0] code);
    if (first_init) begin
      return LD_INIT1;
    end else if (is_long_cmd(rs, code)) begin
      return LD_CLEAR;
    end
    return LD_EXEC;
  endfunction

  // Counter load requests, issued on the cycle each timed state is entered
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_INIT: begin
        cnt_load = 1'b1;
        cnt_val  = LD_SETUP;
      end
      ST_IDLE: begin
        if (i_valid) begin
          cnt_load = 1'b1;
          cnt_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = LD_EHIGH;
        end
      end
      ST_E_HIGH: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = exec_load(!init_done_q && (idx_q == 4'd0), hold_rs_q, hold_code_q);
`ifdef HD44780_NIBBLE_MODE_EN
          if (!low_q && !single_q) begin
            cnt_val = LD_SETUP;
          end
`endif
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  hd44780_delay_counter #(
    .CNT_W  (CNT_W),
    .RST_VAL(LD_POR)
  ) u_delay (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .done_o    (cnt_done)
  );

  // Main sequencer: POR wait, init ROM playback, handshake and pin timing
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_POR_WAIT;
      idx_q       <= '0;
      hold_rs_q   <= 1'b0;
      hold_code_q <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_db_q    <= '0;
`ifdef HD44780_NIBBLE_MODE_EN
      single_q    <= 1'b0;
      low_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_POR_WAIT: begin
          if (cnt_done) begin
            idx_q   <= '0;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          hold_rs_q   <= 1'b0;
          hold_code_q <= rom_code;
          lcd_rs_q    <= 1'b0;
          lcd_db_q    <= bus_first(rom_code);
`ifdef HD44780_NIBBLE_MODE_EN
          single_q    <= rom_single;
          low_q       <= 1'b0;
`endif
          state_q     <= ST_SETUP;
        end
        ST_IDLE: begin
          if (i_valid) begin
            hold_rs_q   <= i_rs;
            hold_code_q <= i_data;
            lcd_rs_q    <= i_rs;
            lcd_db_q    <= bus_first(i_data);
            ready_q     <= 1'b0;
`ifdef HD44780_NIBBLE_MODE_EN
            single_q    <= 1'b0;
            low_q       <= 1'b0;
`endif
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            lcd_e_q <= 1'b1;
            state_q <= ST_E_HIGH;
          end
        end
        ST_E_HIGH: begin
          if (cnt_done) begin
            lcd_e_q <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
`ifdef HD44780_NIBBLE_MODE_EN
            if (!low_q && !single_q) begin
              low_q    <= 1'b1;
              lcd_db_q <= {hold_code_q[3:0], 4'h0};
              state_q  <= ST_SETUP;
            end else begin
              low_q    <= 1'b0;
              state_q  <= ST_EXEC;
            end
`else
            state_q <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          if (cnt_done) begin
            if (init_done_q) begin
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end else if (idx_q == 4'(INIT_LEN - 1)) begin
              init_done_q <= 1'b1;
              ready_q     <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= ST_INIT;
            end
          end
        end
        default: begin
          state_q <= ST_POR_WAIT;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_init_done = init_done_q;
  assign o_lcd_rs    = lcd_rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_e     = lcd_e_q;
  assign o_lcd_db    = lcd_db_q;

endmodule

// File: tb/tb_hd44780_bus_driver.sv
// Directed self-checking bench for hd44780_bus_driver with short timing parameters.
`timescale 1ns/1ps
module tb_hd44780_bus_driver;

  localparam int P_POR = 20, P_SETUP = 2, P_EHIGH = 3, P_HOLD = 2;
  localparam int P_EXEC = 10, P_CLEAR = 30, P_INIT1 = 25;

`ifdef HD44780_NIBBLE_MODE_EN
  localparam int N_INIT = 12;
  localparam logic [7:0] EXP_DB [N_INIT] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
                                             8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};
  localparam int EXP_GAP [N_INIT-1] = '{33, 18, 18, 18, 7, 18, 7, 18, 7, 38, 7};
`else
  localparam int N_INIT = 7;
  localparam logic [7:0] EXP_DB [N_INIT] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
  localparam int EXP_GAP [N_INIT-1] = '{33, 18, 18, 18, 18, 38};
`endif

  logic       clk = 1'b0;
  logic       rst, valid, rs;
  logic [7:0] data;
  logic       ready, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cyc0 = 0;
  int rel_nr = 0;
  int rel_nf = 0;

  hd44780_bus_driver #(
    .T_POR_CYC(P_POR), .T_SETUP_CYC(P_SETUP), .T_EHIGH_CYC(P_EHIGH), .T_HOLD_CYC(P_HOLD),
    .T_EXEC_CYC(P_EXEC), .T_CLEAR_CYC(P_CLEAR), .T_INIT1_CYC(P_INIT1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_rs(rs), .i_data(data),
    .o_ready(ready), .o_init_done(init_done), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_e(lcd_e), .o_lcd_db(lcd_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: rise/fall cycle numbers, bus at each rise, setup length before each rise
  int         nr = 0, nf = 0, bus_chg = 0;
  int         rise_cyc [64];
  int         fall_cyc [64];
  int         rise_setup [64];
  logic [7:0] rise_db [64];
  logic       rise_rs [64];
  logic       e_prev = 1'b0;
  logic [8:0] bus_prev = 9'h0;

  always @(negedge clk) begin
    if ({lcd_rs, lcd_db} !== bus_prev) bus_chg <= cyc;
    if (lcd_e === 1'b1 && !e_prev && nr < 64) begin
      rise_cyc[nr]   <= cyc;
      rise_db[nr]    <= lcd_db;
      rise_rs[nr]    <= lcd_rs;
      rise_setup[nr] <= cyc - bus_chg;
      nr <= nr + 1;
    end
    if (lcd_e === 1'b0 && e_prev && nf < 64) begin
      fall_cyc[nf] <= cyc;
      nf <= nf + 1;
    end
    e_prev   <= (lcd_e === 1'b1);
    bus_prev <= {lcd_rs, lcd_db};
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic release_reset;
    rst = 1'b0;
    cyc0 = cyc;
    rel_nr = nr;
    rel_nf = nf;
  endtask

  task automatic wait_ready(output int t, output bit ok);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    ok = (ready === 1'b1);
    t = cyc;
  endtask

  task automatic check_ready_low_por;
    bit bad;
    bad = 1'b0;
    repeat (P_POR) begin
      step();
      if (ready !== 1'b0 || init_done !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL por_ready_low: ready/init_done went high got=%b%b want=00", ready, init_done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; rs = 1'b0; data = 8'h00;
    repeat (3) step();
    n_cmp++;
    if ({ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_db} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got=%h want=0", {ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_db});
    end
    release_reset();
    check_ready_low_por();
  endtask

  task automatic test_init;
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_bad++;
      $display("FAIL init_timeout: init_done=%b want=1", init_done);
      return;
    end
    n_cmp++;
    if (nr - rel_nr != N_INIT) begin
      n_bad++;
      $display("FAIL init_pulse_count: got=%0d want=%0d", nr - rel_nr, N_INIT);
      return;
    end
    n_cmp++;
    if (rise_cyc[rel_nr] - cyc0 != P_POR + 1 + P_SETUP) begin
      n_bad++;
      $display("FAIL init_first_rise: got=%0d want=%0d", rise_cyc[rel_nr] - cyc0, P_POR + 1 + P_SETUP);
    end
    n_cmp++;
    if (rise_setup[rel_nr] != P_SETUP) begin
      n_bad++;
      $display("FAIL init_setup: got=%0d want=%0d", rise_setup[rel_nr], P_SETUP);
    end
    for (int i = 0; i < N_INIT; i++) begin
      n_cmp++;
      if (rise_db[rel_nr+i] !== EXP_DB[i] || rise_rs[rel_nr+i] !== 1'b0) begin
        n_bad++;
        $display("FAIL init_db[%0d]: got rs=%b db=%h want rs=0 db=%h", i,
                 rise_rs[rel_nr+i], rise_db[rel_nr+i], EXP_DB[i]);
      end
      n_cmp++;
      if (fall_cyc[rel_nf+i] - rise_cyc[rel_nr+i] != P_EHIGH) begin
        n_bad++;
        $display("FAIL init_ehigh[%0d]: got=%0d want=%0d", i,
                 fall_cyc[rel_nf+i] - rise_cyc[rel_nr+i], P_EHIGH);
      end
    end
    for (int i = 0; i < N_INIT - 1; i++) begin
      n_cmp++;
      if (rise_cyc[rel_nr+i+1] - rise_cyc[rel_nr+i] != EXP_GAP[i]) begin
        n_bad++;
        $display("FAIL init_gap[%0d]: got=%0d want=%0d", i,
                 rise_cyc[rel_nr+i+1] - rise_cyc[rel_nr+i], EXP_GAP[i]);
      end
    end
    n_cmp++;
    if (cyc - rise_cyc[rel_nr+N_INIT-1] != P_EHIGH + P_HOLD + P_EXEC || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL init_done_time: got=%0d ready=%b want=%0d ready=1",
               cyc - rise_cyc[rel_nr+N_INIT-1], ready, P_EHIGH + P_HOLD + P_EXEC);
    end
  endtask

  task automatic test_single;
    int a, b0, bf, t;
    bit ok, moved;
    b0 = nr; bf = nf; moved = 1'b0;
    valid = 1'b1; rs = 1'b1; data = 8'h35; a = cyc + 1;
    step();
    valid = 1'b0; data = 8'hFF;
    n_cmp++;
    if (ready !== 1'b0 || lcd_rs !== 1'b1 || lcd_db !== 8'h35) begin
      n_bad++;
      $display("FAIL single_accept: got ready=%b rs=%b db=%h want 0 1 35", ready, lcd_rs, lcd_db);
    end
    for (int n = 0; n < 400 && ready !== 1'b1; n++) begin
      step();
      if (lcd_rs !== 1'b1 || lcd_db !== 8'h35) moved = 1'b1;
    end
    ok = (ready === 1'b1);
    t = cyc;
    n_cmp++;
    if (!ok || t - a != P_SETUP + P_EHIGH + P_HOLD + P_EXEC) begin
      n_bad++;
      $display("FAIL single_ready_return: got=%0d ok=%b want=%0d", t - a, ok,
               P_SETUP + P_EHIGH + P_HOLD + P_EXEC);
    end
    n_cmp++;
    if (moved) begin
      n_bad++;
      $display("FAIL single_hold: got bus changed before ready want stable rs=1 db=35");
    end
    n_cmp++;
    if (nr - b0 != 1 || rise_cyc[b0] - a != P_SETUP || rise_setup[b0] != P_SETUP ||
        rise_db[b0] !== 8'h35 || rise_rs[b0] !== 1'b1 || fall_cyc[bf] - rise_cyc[b0] != P_EHIGH) begin
      n_bad++;
      $display("FAIL single_pulse: got n=%0d rise=%0d setup=%0d db=%h rs=%b width=%0d want 1 2 2 35 1 3",
               nr - b0, rise_cyc[b0] - a, rise_setup[b0], rise_db[b0], rise_rs[b0],
               fall_cyc[bf] - rise_cyc[b0]);
    end
  endtask

  task automatic test_back_to_back;
    int a, b0, t;
    bit ok;
    b0 = nr;
    valid = 1'b1; rs = 1'b0; data = 8'h80; a = cyc + 1;
    step();
    rs = 1'b1; data = 8'h41;
    wait_ready(t, ok);
    n_cmp++;
    if (!ok || t - a != P_SETUP + P_EHIGH + P_HOLD + P_EXEC) begin
      n_bad++;
      $display("FAIL b2b_first_ready: got=%0d ok=%b want=17", t - a, ok);
    end
    step();
    valid = 1'b0;
    n_cmp++;
    if (ready !== 1'b0 || lcd_db !== 8'h41) begin
      n_bad++;
      $display("FAIL b2b_first_idle_accept: got ready=%b db=%h want 0 41", ready, lcd_db);
    end
    wait_ready(t, ok);
    n_cmp++;
    if (!ok || nr - b0 != 2 || rise_db[b0] !== 8'h80 || rise_rs[b0] !== 1'b0 ||
        rise_db[b0+1] !== 8'h41 || rise_rs[b0+1] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_bytes: got n=%0d %b/%h %b/%h want 2 0/80 1/41", nr - b0,
               rise_rs[b0], rise_db[b0], rise_rs[b0+1], rise_db[b0+1]);
    end
    n_cmp++;
    if (rise_cyc[b0] - a != P_SETUP || rise_cyc[b0+1] - rise_cyc[b0] != 18) begin
      n_bad++;
      $display("FAIL b2b_timing: got first=%0d gap=%0d want 2 18", rise_cyc[b0] - a,
               rise_cyc[b0+1] - rise_cyc[b0]);
    end
  endtask

  task automatic test_exec_wait;
    logic       v_rs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] v_db [5] = '{8'h01, 8'h01, 8'h03, 8'h02, 8'h04};
    int         v_w  [5] = '{P_CLEAR, P_EXEC, P_CLEAR, P_CLEAR, P_EXEC};
    int a, t;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; rs = v_rs[i]; data = v_db[i]; a = cyc + 1;
      step();
      valid = 1'b0;
      wait_ready(t, ok);
      n_cmp++;
      if (!ok || t - a != P_SETUP + P_EHIGH + P_HOLD + v_w[i]) begin
        n_bad++;
        $display("FAIL exec_wait rs=%b db=%h: got=%0d ok=%b want=%0d", v_rs[i], v_db[i],
                 t - a, ok, P_SETUP + P_EHIGH + P_HOLD + v_w[i]);
      end
    end
  endtask

  task automatic test_nibble;
    int a, b0, t;
    bit low_bad;
    b0 = nr; low_bad = 1'b0;
    valid = 1'b1; rs = 1'b1; data = 8'h50; a = cyc + 1;
    step();
    valid = 1'b0;
    for (int n = 0; n < 400 && ready !== 1'b1; n++) begin
      if (lcd_db[3:0] !== 4'h0) low_bad = 1'b1;
      step();
    end
    t = cyc;
    n_cmp++;
    if (low_bad) begin
      n_bad++;
      $display("FAIL nibble_low_zero: got DB[3:0] nonzero want 0");
    end
    n_cmp++;
    if (nr - b0 != 2 || rise_db[b0] !== 8'h50 || rise_db[b0+1] !== 8'h00 ||
        rise_rs[b0] !== 1'b1 || rise_rs[b0+1] !== 1'b1) begin
      n_bad++;
      $display("FAIL nibble_bytes: got n=%0d %h %h want 2 50 00", nr - b0, rise_db[b0], rise_db[b0+1]);
    end
    n_cmp++;
    if (rise_cyc[b0] - a != 2 || rise_cyc[b0+1] - rise_cyc[b0] != 7 || t - a != 24) begin
      n_bad++;
      $display("FAIL nibble_timing: got %0d %0d %0d want 2 7 24", rise_cyc[b0] - a,
               rise_cyc[b0+1] - rise_cyc[b0], t - a);
    end
  endtask

  task automatic test_reset_midpulse;
    int n;
    valid = 1'b1; rs = 1'b1; data = 8'h55;
    step();
    valid = 1'b0;
    n = 0;
    while (lcd_e !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_cmp++;
    if (lcd_e !== 1'b1) begin
      n_bad++;
      $display("FAIL midpulse_e_high: got e=%b want 1", lcd_e);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_db} !== 13'h0) begin
      n_bad++;
      $display("FAIL midpulse_reset_outputs: got=%h want=0",
               {ready, init_done, lcd_rs, lcd_rw, lcd_e, lcd_db});
    end
    release_reset();
    check_ready_low_por();
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
`ifdef HD44780_NIBBLE_MODE_EN
    test_nibble();
`else
    test_single();
    test_back_to_back();
    test_exec_wait();
`endif
    test_reset_midpulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
